td4_input_port: RTL

- Input stage that feeds the TD4 CPU's IN A / IN B instructions from four raw active-low push buttons.
- Per button: synchronises to clk, debounces, and produces a stable active-high level plus one-cycle press/release pulses.
- Presents a 4-bit in_data word that changes only on CPU step ticks, so an IN instruction always sees a value that is constant across the step.
- Optional sticky mode latches short presses until the CPU acknowledges them, so presses between slow CPU steps are not lost.

---
 rtl/td4_input_port_if.sv | 24 ++
 rtl/td4_input_port.sv | 121 ++++++++++++
 2 files changed

// File: rtl/td4_input_port_if.sv
// Button-to-CPU handshake bundle for td4_input_port: raw pins and CPU strobes in, debounced state out.
// Latency: none (wires only); backpressure: none, the CPU samples in_data on its own step ticks.
interface td4_input_port_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] btn_n;
    logic             cpu_tick;
    logic             in_ack;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press;
    // 'release' is a reserved word, so the release pulse vector is named rel
    logic [WIDTH-1:0] rel;

    modport master (
        output btn_n, cpu_tick, in_ack,
        input  in_data, level, press, rel
    );

    modport slave (
        input  btn_n, cpu_tick, in_ack,
        output in_data, level, press, rel
    );
endinterface

// File: rtl/td4_input_port.sv
// TD4 input stage: sync + debounce of active-low buttons, press/release pulses, step-stable in_data.
// Latency: pin edge to level/pulse is 2+DEB_CYCLES clk edges; in_data follows on the next cpu_tick.
// Backpressure: none; sticky latches hold short presses until the CPU acknowledges with in_ack.
module td4_input_port #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 270000,
    parameter int STICKY     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    td4_input_port_if.slave   bus
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_t;

    logic [WIDTH-1:0] s1_n;
    logic [WIDTH-1:0] s2_n;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] rel_q;
    logic [WIDTH-1:0] sticky_q;
    logic [WIDTH-1:0] in_data_q;

    // Synchroniser resets to the released (high) pin state so no phantom press follows reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_n <= '1;
            s2_n <= '1;
        end else begin
            s1_n <= bus.btn_n;
            s2_n <= s1_n;
        end
    end

    assign sync = ~s2_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        deb_state_t    state;
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          prs;
        logic          rls;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_STABLE;
                cnt   <= '0;
                lvl   <= 1'b0;
                prs   <= 1'b0;
                rls   <= 1'b0;
            end else begin
                prs <= 1'b0;
                rls <= 1'b0;
                case (state)
                    ST_STABLE: begin
                        if (sync[i] != lvl) begin
                            state <= ST_CHANGING;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_CHANGING: begin
                        if (sync[i] == lvl) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            lvl   <= sync[i];
                            prs   <= sync[i];
                            rls   <= ~sync[i];
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign level_q[i] = lvl;
        assign press_q[i] = prs;
        assign rel_q[i]   = rls;
    end

    // A press on the same edge as in_ack survives: set wins over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else if (STICKY != 0) begin
            sticky_q <= press_q | (bus.in_ack ? '0 : sticky_q);
        end else begin
            sticky_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data_q <= '0;
        end else if (bus.cpu_tick) begin
            in_data_q <= level_q | sticky_q;
        end
    end

    assign bus.level   = level_q;
    assign bus.press   = press_q;
    assign bus.rel     = rel_q;
    assign bus.in_data = in_data_q;

endmodule
